// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite slave fronting a single-port SRAM through a one-entry write buffer; define AHB_SRAM_WAIT_EN for WAIT_CYCLES read wait states
module ahb_sram_slave #(
  parameter int ADDR_W = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA,
  output logic              SRAM_CS,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [3:0]        SRAM_WEN,
  output logic [31:0]       SRAM_WDATA,
  input  logic [31:0]       SRAM_RDATA
);
  typedef enum logic [2:0] {IDLE, RD, WR, ERR1, ERR2} state_t;
  state_t state;
  logic [ADDR_W-1:0] haddr_w, addr_q, buf_addr;
  logic [3:0] mask, mask_q, buf_mask;
  logic [31:0] buf_data, rdata_q, merged;
  logic buf_valid, legal, accept, rd_sel, drain, hold, rd_done, unused;

`ifdef AHB_SRAM_WAIT_EN
  logic [3:0] cnt;
  assign hold = state == RD && cnt != 4'd0;
  assign unused = ^{HADDR[31:ADDR_W+2], HTRANS[0]};
  // Read wait-state down-counter, loaded on each read select
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) cnt <= '0;
    else if (rd_sel) cnt <= 4'(WAIT_CYCLES);
    else if (hold) cnt <= cnt - 4'd1;
`else
  assign hold = 1'b0;
  assign unused = ^{HADDR[31:ADDR_W+2], HTRANS[0], 4'(WAIT_CYCLES)};
`endif

  assign haddr_w = HADDR[ADDR_W+1:2];
  assign accept = HRESETn & HSEL & HTRANS[1] & HREADY & ~hold & (state != ERR1);
  assign legal = HSIZE == 3'd0 || (HSIZE == 3'd1 && !HADDR[0]) || (HSIZE == 3'd2 && HADDR[1:0] == 2'd0);
  assign mask = HSIZE == 3'd0 ? 4'b0001 << HADDR[1:0] : HSIZE == 3'd1 ? (HADDR[1] ? 4'b1100 : 4'b0011) : 4'hF;
  assign rd_sel = accept & legal & ~HWRITE;
  assign drain = buf_valid & ~rd_sel & ~hold;
  assign rd_done = state == RD && !hold;

  assign HREADYOUT = state != ERR1 && !hold;
  assign HRESP = state == ERR1 || state == ERR2;
  assign HRDATA = rd_done ? merged : rdata_q;
  assign SRAM_CS = rd_sel | hold | drain;
  assign SRAM_ADDR = rd_sel ? haddr_w : hold ? addr_q : buf_addr;
  assign SRAM_WEN = drain ? buf_mask : 4'h0;
  assign SRAM_WDATA = buf_data;

  // Overlay buffered bytes onto SRAM read data when the pending write targets the same word
  always_comb begin
    merged = SRAM_RDATA;
    for (int i = 0; i < 4; i++)
      if (buf_valid && buf_addr == addr_q && buf_mask[i]) merged[8*i +: 8] = buf_data[8*i +: 8];
  end

  // Transfer FSM and address-phase capture
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state <= IDLE;
      addr_q <= '0;
      mask_q <= '0;
    end else begin
      if (state == ERR1) state <= ERR2;
      else if (!hold) state <= !accept ? IDLE : !legal ? ERR1 : HWRITE ? WR : RD;
      if (accept && legal) begin
        addr_q <= haddr_w;
        mask_q <= mask;
      end
    end

  // Write buffer: loads in the write data phase, clears once drained to the SRAM
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      buf_valid <= 1'b0;
      buf_addr <= '0;
      buf_mask <= '0;
      buf_data <= '0;
    end else if (state == WR) begin
      buf_valid <= 1'b1;
      buf_addr <= addr_q;
      buf_mask <= mask_q;
      buf_data <= HWDATA;
    end else if (drain) buf_valid <= 1'b0;

  // Hold the last returned read data outside the read data phase
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) rdata_q <= '0;
    else if (rd_done) rdata_q <= merged;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: table-driven and randomized checks of ahb_sram_slave against a byte-level memory model
module tb_ahb_sram_slave;
`ifdef AHB_SRAM_WAIT_EN
  localparam int WS = 2;
`else
  localparam int WS = 0;
`endif
  localparam int MW = 4096;

  typedef struct {
    logic sel; logic [1:0] tr; logic wr; logic [2:0] sz; logic [31:0] ad; logic [31:0] wd;
    logic use_e; logic e_err; logic [31:0] e_rd;
  } vec_t;
  typedef struct {
    logic v; logic wr; logic err; logic [2:0] sz; logic [31:0] ad; logic [31:0] wd;
    logic use_e; logic [31:0] e_rd;
  } pend_t;

  logic clk = 0, rst_n, hsel, hwrite, hr_en, hready, hreadyout, hresp, sram_cs;
  logic [1:0] htrans;
  logic [2:0] hsize;
  logic [31:0] haddr, hwdata, hrdata, sram_wdata, sram_rdata;
  logic [11:0] sram_addr;
  logic [3:0] sram_wen;
  logic [31:0] mem [MW];
  logic [31:0] ref_mem [MW];
  logic m_cs [8192];
  logic [3:0] m_wen [8192];
  logic [11:0] m_addr [8192];
  int cyc = 0, n_tests = 0, n_fail = 0, wr20 = 0, last_acc = 0;
  int acc_at [17];
  vec_t tbl [17];
  pend_t pend;

  assign hready = hreadyout & hr_en;

  ahb_sram_slave #(.ADDR_W(12), .WAIT_CYCLES(2)) dut (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready), .HREADYOUT(hreadyout), .HRESP(hresp),
    .HRDATA(hrdata), .SRAM_CS(sram_cs), .SRAM_ADDR(sram_addr), .SRAM_WEN(sram_wen),
    .SRAM_WDATA(sram_wdata), .SRAM_RDATA(sram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    m_cs[cyc % 8192] = sram_cs;
    m_wen[cyc % 8192] = sram_wen;
    m_addr[cyc % 8192] = sram_addr;
  end

  function automatic logic [31:0] init_word(input int i);
    return i * 32'h9E3779B1 ^ 32'h5A5A5A5A;
  endfunction

  // Synchronous SRAM macro: read data one cycle after a read select
  initial begin
    for (int i = 0; i < MW; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (sram_cs) begin
        if (sram_wen == 4'h0) sram_rdata <= mem[sram_addr];
        else begin
          if (sram_addr == 12'h8) wr20++;
          for (int b = 0; b < 4; b++) if (sram_wen[b]) mem[sram_addr][8*b +: 8] = sram_wdata[8*b +: 8];
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % MW);
  endfunction

  function automatic logic legal_of(input logic [2:0] sz, input logic [31:0] ad);
    return sz <= 3'd2 && (ad % (32'd1 << sz)) == 0;
  endfunction

  task automatic ref_write(input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] wd);
    for (int b = 0; b < (1 << sz); b++) begin
      int lane = (int'(ad[1:0]) + b) % 4;
      ref_mem[widx(ad)][8*lane +: 8] = wd[8*lane +: 8];
    end
  endtask

  function automatic vec_t mk(input logic sel, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                              input logic [31:0] ad, input logic [31:0] wd, input logic use_e,
                              input logic e_err, input logic [31:0] e_rd);
    vec_t t;
    t.sel = sel; t.tr = tr; t.wr = wr; t.sz = sz; t.ad = ad; t.wd = wd;
    t.use_e = use_e; t.e_err = e_err; t.e_rd = e_rd;
    return t;
  endfunction

  task automatic finish_phase(input int waits);
    int exp_w = !pend.v ? 0 : pend.err ? 1 : pend.wr ? 0 : WS;
    chk("wait_states", waits, exp_w);
    chk("hresp", hresp, pend.v & pend.err);
    if (pend.v && !pend.err) begin
      if (pend.wr) ref_write(pend.sz, pend.ad, pend.wd);
      else begin
        chk("rdata", hrdata, ref_mem[widx(pend.ad)]);
        if (pend.use_e) chk("rdata_table", hrdata, pend.e_rd);
      end
    end
  endtask

  // One address phase, completing the previous data phase alongside it
  task automatic xfer(input vec_t t);
    int waits = 0;
    hsel = t.sel; htrans = t.tr; hwrite = t.wr; hsize = t.sz; haddr = t.ad; hwdata = pend.wd;
    @(negedge clk);
    while (!hready && waits < 20) begin
      if (pend.v && pend.err) chk("err1_hresp", hresp, 1'b1);
      waits++;
      @(negedge clk);
    end
    last_acc = cyc;
    finish_phase(waits);
    @(posedge clk); #1;
    pend.v = t.sel & t.tr[1];
    pend.wr = t.wr; pend.sz = t.sz; pend.ad = t.ad; pend.wd = t.wd;
    pend.err = t.use_e ? t.e_err : !legal_of(t.sz, t.ad);
    pend.use_e = t.use_e; pend.e_rd = t.e_rd;
  endtask

  function automatic int first_wr(input int from);
    for (int i = from; i < cyc; i++) if (m_wen[i % 8192] != 4'h0) return i;
    return -1;
  endfunction

  initial begin
    int w, diffs;
    vec_t idle, r;
    idle = mk(0, 2'b00, 0, 3'd0, 0, 0, 0, 0, 0);
    for (int i = 0; i < MW; i++) ref_mem[i] = init_word(i);
    pend.v = 0; pend.wd = 0;
    rst_n = 0; hr_en = 1; hsel = 0; htrans = 0; hwrite = 0; hsize = 0; haddr = 0; hwdata = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_hreadyout", hreadyout, 1'b1);
    chk("rst_hresp", hresp, 1'b0);
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_sram_cs", sram_cs, 1'b0);
    chk("rst_sram_wen", sram_wen, 4'h0);
    @(posedge clk); #1;

    tbl[0]  = mk(1, 2'b10, 1, 3'd2, 32'h10, 32'hCAFEF00D, 1, 0, 0);
    tbl[1]  = mk(1, 2'b10, 0, 3'd2, 32'h10, 0, 1, 0, 32'hCAFEF00D);
    tbl[2]  = idle;
    tbl[3]  = idle;
    tbl[4]  = mk(1, 2'b10, 1, 3'd0, 32'h13, 32'hAB000000, 1, 0, 0);
    tbl[5]  = idle;
    tbl[6]  = mk(1, 2'b11, 0, 3'd2, 32'h10, 0, 1, 0, 32'hABFEF00D);
    tbl[7]  = idle;
    tbl[8]  = idle;
    tbl[9]  = mk(1, 2'b10, 0, 3'd2, 32'h02, 0, 1, 1, 0);
    tbl[10] = mk(1, 2'b10, 0, 3'd3, 32'h00, 0, 1, 1, 0);
    tbl[11] = idle;
    tbl[12] = mk(1, 2'b10, 0, 3'd2, 32'h40, 0, 0, 0, 0);
    tbl[13] = mk(0, 2'b10, 0, 3'd2, 32'h44, 0, 1, 0, 0);
    tbl[14] = mk(1, 2'b01, 0, 3'd2, 32'h48, 0, 1, 0, 0);
    tbl[15] = mk(1, 2'b00, 1, 3'd2, 32'h4C, 32'h12345678, 1, 0, 0);
    tbl[16] = idle;
    for (int i = 0; i < 17; i++) begin
      xfer(tbl[i]);
      acc_at[i] = last_acc;
    end

    w = first_wr(acc_at[0]);
    chk("t1_drain_cycle", w - acc_at[0], 2 + WS);
    chk("t1_drain_wen", m_wen[(w < 0 ? 0 : w) % 8192], 4'hF);
    chk("t1_drain_addr", m_addr[(w < 0 ? 0 : w) % 8192], 12'h4);
    w = first_wr(acc_at[4]);
    chk("t2_drain_wen", m_wen[(w < 0 ? 0 : w) % 8192], 4'b1000);
    chk("t2_drain_addr", m_addr[(w < 0 ? 0 : w) % 8192], 12'h4);
    for (int k = 0; k < 3; k++) begin
      chk("t3_misaligned_cs", m_cs[(acc_at[9] + k) % 8192], 1'b0);
      chk("t3_size3_cs", m_cs[(acc_at[10] + k) % 8192], 1'b0);
    end
    for (int k = 0; k <= WS; k++) begin
      chk("t6_read_cs", m_cs[(acc_at[12] + k) % 8192], 1'b1);
      chk("t6_read_addr", m_addr[(acc_at[12] + k) % 8192], 12'h10);
    end
    for (int c = acc_at[13]; c <= acc_at[16]; c++) chk("t4_no_select_cs", m_cs[c % 8192], 1'b0);

    hsel = 1; htrans = 2'b10; hwrite = 0; hsize = 3'd2; haddr = 32'h44; hr_en = 0;
    @(negedge clk);
    chk("hready_low_cs", sram_cs, 1'b0);
    chk("hready_low_hreadyout", hreadyout, 1'b1);
    chk("hready_low_hresp", hresp, 1'b0);
    @(posedge clk); #1 hr_en = 1;
    xfer(idle);
    chk("hready_low_no_read", m_cs[last_acc % 8192], 1'b0);

    xfer(mk(1, 2'b10, 1, 3'd2, 32'h20, 32'hDEADBEEF, 0, 0, 0));
    hsel = 0; htrans = 0; hwdata = 32'hDEADBEEF; rst_n = 0;
    @(negedge clk);
    chk("midrst_hreadyout", hreadyout, 1'b1);
    chk("midrst_hresp", hresp, 1'b0);
    chk("midrst_hrdata", hrdata, 32'h0);
    chk("midrst_sram_cs", sram_cs, 1'b0);
    chk("midrst_sram_wen", sram_wen, 4'h0);
    @(posedge clk); #1 rst_n = 1;
    pend.v = 0;
    repeat (4) xfer(idle);
    chk("midrst_no_write_0x20", wr20, 0);

    for (int i = 0; i < 500; i++) begin
      r.sel = $urandom_range(0, 7) != 0;
      r.tr = $urandom_range(0, 3) == 0 ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      r.wr = 1'($urandom_range(0, 1));
      r.sz = $urandom_range(0, 9) == 0 ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      r.ad = {($urandom_range(0, 3) == 0 ? 18'($urandom) : 18'd0), 14'($urandom_range(0, 63))};
      r.wd = $urandom;
      r.use_e = 0; r.e_err = 0; r.e_rd = 0;
      xfer(r);
    end
    repeat (6) xfer(idle);

    diffs = 0;
    for (int i = 0; i < MW; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("sram_contents_diffs", diffs, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite slave that fronts a synchronous single-port 32-bit SRAM macro.
- Produces the HRDATA_Sx / HREADYOUT_Sx pair consumed by the system read-data/ready multiplexer, and takes the bus-level HREADY back from it.
- Zero-wait-state reads and writes. A one-entry write buffer removes the write-data-phase / read-address-phase port conflict.
- Unsupported or misaligned transfers get a two-cycle ERROR response.

Parameters:
- ADDR_W, 12, SRAM word-address width (2^ADDR_W words; 12 = 16 KB).
- WAIT_CYCLES, 1, read wait states inserted when AHB_SRAM_WAIT_EN is defined (range 1..15); ignored otherwise.

Ports:
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select from address decoder.
- HADDR  in  32  byte address; bits above ADDR_W+1 ignored (aliasing).
- HTRANS  in  2  transfer type; only NONSEQ/SEQ (HTRANS[1]=1) start transfers.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 byte, 1 halfword, 2 word; >2 unsupported.
- HWDATA  in  32  write data, valid in data phase.
- HREADY  in  1  bus ready returned from the read-data mux.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 OKAY, 1 ERROR.
- HRDATA  out  32  read data.
- SRAM_CS  out  1  SRAM chip select.
- SRAM_ADDR  out  ADDR_W  SRAM word address.
- SRAM_WEN  out  4  per-byte write enables; 0 = read.
- SRAM_WDATA  out  32  SRAM write data.
- SRAM_RDATA  in  32  SRAM read data, valid one cycle after a read-select cycle.

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, SRAM_CS=0, SRAM_WEN=0. Write buffer invalid; FSM in IDLE.
- Accept = HSEL & HTRANS[1] & HREADY. Address-phase controls are registered only on accept; IDLE/BUSY transfers leave the slave idle with an OKAY response.
- Legality check:
  - HSIZE=1 requires HADDR[0]=0.
  - HSIZE=2 requires HADDR[1:0]=0.
  - HSIZE>2 is illegal.
- Byte mask from HSIZE/HADDR[1:0]: byte = 1<<a[1:0]; half = 3<<{a[1],0}; word = 4'hF.
- FSM states: IDLE, RD (read data phase), WR (write data phase), ERR1, ERR2.
  - IDLE/RD/WR on legal accept: RD or WR. On illegal accept: ERR1. No accept: IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Accept in this cycle is evaluated as in IDLE.
- Illegal transfers never assert SRAM_CS and never touch the buffer.
- Read:
  - SRAM_CS=1, SRAM_WEN=0, SRAM_ADDR=HADDR[ADDR_W+1:2] in the accept cycle.
  - In RD, HRDATA = SRAM_RDATA with buffered bytes substituted when buffer valid and buffer address equals read address (per-byte merge by mask).
  - HREADYOUT=1, zero wait.
- Write:
  - Accept cycle registers address and mask.
  - In WR, HWDATA/addr/mask load the buffer at the end of the cycle; buffer valid=1.
- Drain: in any cycle with no read select and no read wait in flight, a valid buffer is written.
  - SRAM_CS=1, SRAM_WEN=mask, SRAM_WDATA=buffer data; valid clears next edge.
  - A write accept is never a read select, so the old entry always drains before the new data loads. The buffer never overflows.
- Back-to-back write->read to the same address returns the new data via the merge path, without SRAM involvement.
- HRDATA holds its last value outside RD.
- Reset mid-operation: buffered write discarded (no SRAM write), FSM to IDLE immediately.

Optional Feature:
- Macro AHB_SRAM_WAIT_EN.
- Defined:
  - Each read data phase holds HREADYOUT=0 for WAIT_CYCLES cycles via a down-counter; HREADYOUT=1 on the final cycle.
  - SRAM_CS/SRAM_ADDR are held for the whole phase; HRDATA is sampled (with merge) on the final cycle.
  - Drain is blocked while the read is in flight.
  - Writes and errors are unchanged.
- Undefined: counter absent; all reads are zero-wait.

Test Plan:
- Word write 0xCAFEF00D @0x10, next cycle read @0x10 -> HRDATA=0xCAFEF00D, HREADYOUT=1 throughout; SRAM write (WEN=4'hF, ADDR=4) occurs only in the first later idle cycle.
- Byte write 0xAB on lane 3 @0x13 (HSIZE=0), idle, then word read @0x10 -> SRAM_WEN=4'b1000 on drain; read = 0xABFEF00D.
- Word read @0x02 -> cycle1 HREADYOUT=0/HRESP=1, cycle2 HREADYOUT=1/HRESP=1; SRAM_CS=0 both cycles. Repeat with HSIZE=3 @0x0 -> same response.
- HSEL=0, or HTRANS=IDLE/BUSY, or HREADY=0 with valid controls -> no SRAM_CS, HREADYOUT=1, HRESP=0.
- Write @0x20, assert HRESETn=0 in the data-phase cycle -> outputs at reset values, buffer invalid; no SRAM write ever issued for 0x20.
- AHB_SRAM_WAIT_EN, WAIT_CYCLES=2, read @0x40 -> HREADYOUT low exactly 2 cycles, SRAM_ADDR=0x10 held, valid HRDATA on the third cycle.
